touch_key_filter: RTL and testbench

//   Upstream conditioning stage for the capacitive touch key. Takes the raw,

---
 rtl/touch_key_filter_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/touch_key_filter.sv | 145 ++++++++++++++
 tb/tb_touch_key_filter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_key_filter_pkg.sv
// Shared definitions for the touch key conditioning path: FSM state encodings
// and the default debounce/long-press windows for a 50 MHz sys_clk.
package touch_key_filter_pkg;

    localparam int DEB_CNT_DEF  = 1000000;   // 20 ms
    localparam int LONG_CNT_DEF = 50000000;  // 1 s

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_REL_DEB   = 2'd3
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous pad inputs; 2-cycle
// latency, synchronous active-low reset clears both stages.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic d0_q;
    logic d1_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            d0_q <= 1'b0;
            d1_q <= 1'b0;
        end else begin
            d0_q <= d_i;
            d1_q <= d0_q;
        end
    end

    assign q_o = d1_q;

endmodule

// File: rtl/touch_key_filter.sv
// Touch key debounce: clean level plus registered press/release pulses, and a
// long-press pulse when built with TOUCH_KEY_LONG_PRESS_EN (otherwise key_long=0).
module touch_key_filter
    import touch_key_filter_pkg::*;
#(
    parameter int DEB_CNT  = DEB_CNT_DEF,
    parameter int LONG_CNT = LONG_CNT_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic touch_key,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int            DW       = $clog2(DEB_CNT);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

    logic          key_s;
    state_e        state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    sync_2ff u_sync (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .d_i     (touch_key),
        .q_o     (key_s)
    );

    // A change of key_s is checked before the window end so it always wins.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_s) begin
                    state_d   = ST_PRESS_DEB;
                    deb_cnt_d = '0;
                end
            end
            ST_PRESS_DEB: begin
                if (!key_s) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = ST_PRESSED;
                    deb_cnt_d = '0;
                    press_d   = 1'b1;
                    level_d   = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!key_s) begin
                    state_d   = ST_REL_DEB;
                    deb_cnt_d = '0;
                end
            end
            ST_REL_DEB: begin
                if (key_s) begin
                    state_d   = ST_PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                deb_cnt_d = '0;
                level_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef TOUCH_KEY_LONG_PRESS_EN
    localparam int            LW        = $clog2(LONG_CNT);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CNT - 1);
    localparam logic [LW-1:0] LONG_PRE  = LW'(LONG_CNT - 2);

    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          long_q, long_d;

    // Saturating at LONG_LAST is what stops a second pulse within one hold.
    always_comb begin
        long_cnt_d = long_cnt_q;
        long_d     = 1'b0;
        if (state_q == ST_IDLE) begin
            long_cnt_d = '0;
        end else if ((state_q == ST_PRESSED || state_q == ST_REL_DEB) &&
                     (long_cnt_q != LONG_LAST)) begin
            long_cnt_d = long_cnt_q + 1'b1;
            long_d     = (long_cnt_q == LONG_PRE);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
        end
    end

    assign key_long = long_q;
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_touch_key_filter.sv
// Scoreboard bench for touch_key_filter with DEB_CNT=4, LONG_CNT=20.
module tb_touch_key_filter;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic touch_key;
    logic key_level, key_press, key_release, key_long;

    touch_key_filter #(.DEB_CNT(DEB), .LONG_CNT(LONG)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .touch_key   (touch_key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    ev_t  sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_p, exp_r, exp_l;
    logic exp_lvl = 1'b0;

    task automatic expect_ev(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and pop any expectations due this cycle.
    task automatic step();
        @(negedge sys_clk);
        exp_p = 1'b0;
        exp_r = 1'b0;
        exp_l = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    K_PRESS:   begin exp_p = 1'b1; exp_lvl = 1'b1; end
                    K_RELEASE: begin exp_r = 1'b1; exp_lvl = 1'b0; end
                    default:   exp_l = 1'b1;
                endcase
                sb.delete(i);
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        touch_key = 1'b1;
        repeat (5) begin
            step();
            vectors++;
            if ({key_level, key_press, key_release, key_long} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset cyc=%0d lvl/prs/rel/lng got=%b want=0000", cyc,
                         {key_level, key_press, key_release, key_long});
            end
        end
        touch_key = 1'b0;
        step();
        sys_rst_n = 1'b1;
        repeat (4) begin
            step();
            vectors++;
            if ({key_level, key_press, key_release, key_long} !== 4'b0000) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d got=%b want=0000", cyc,
                         {key_level, key_press, key_release, key_long});
            end
        end
    endtask

    task automatic test_clean_press();
        step();
        touch_key = 1'b1;
        expect_ev(cyc + DEB + 3, K_PRESS);
        repeat (DEB + 5) begin
            step();
            vectors++;
            if ({key_level, key_press, key_release, key_long} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                miscompares++;
                $display("FAIL clean_press cyc=%0d got=%b want=%b", cyc,
                         {key_level, key_press, key_release, key_long}, {exp_lvl, exp_p, exp_r, exp_l});
            end
        end
        touch_key = 1'b0;
        expect_ev(cyc + DEB + 3, K_RELEASE);
        repeat (DEB + 6) begin
            step();
            vectors++;
            if ({key_level, key_press, key_release, key_long} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                miscompares++;
                $display("FAIL clean_release cyc=%0d got=%b want=%b", cyc,
                         {key_level, key_press, key_release, key_long}, {exp_lvl, exp_p, exp_r, exp_l});
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL clean_pending got=%0d want=0 events", sb.size());
            sb.delete();
        end
    endtask

    // High for 3 and DEB cycles: rejected (DEB hits the window end as the key drops).
    // High for DEB+1 cycles: the shortest pulse that is accepted.
    task automatic test_glitch();
        int widths[3];
        widths[0] = 3;
        widths[1] = DEB;
        widths[2] = DEB + 1;
        for (int w = 0; w < 3; w++) begin
            step();
            touch_key = 1'b1;
            if (w == 2) expect_ev(cyc + DEB + 3, K_PRESS);
            repeat (widths[w]) begin
                step();
                vectors++;
                if ({key_level, key_press, key_release, key_long} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                    miscompares++;
                    $display("FAIL glitch_w%0d_hi cyc=%0d got=%b want=%b", widths[w], cyc,
                             {key_level, key_press, key_release, key_long}, {exp_lvl, exp_p, exp_r, exp_l});
                end
            end
            touch_key = 1'b0;
            if (w == 2) expect_ev(cyc + DEB + 3, K_RELEASE);
            repeat (DEB + 8) begin
                step();
                vectors++;
                if ({key_level, key_press, key_release, key_long} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                    miscompares++;
                    $display("FAIL glitch_w%0d_lo cyc=%0d got=%b want=%b", widths[w], cyc,
                             {key_level, key_press, key_release, key_long}, {exp_lvl, exp_p, exp_r, exp_l});
                end
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL glitch_pending got=%0d want=0 events", sb.size());
            sb.delete();
        end
    endtask

    // Press, then low 2 / high 3 / low DEB / high 2, then steady low.
    task automatic test_release_bounce();
        int seg_len[5];
        logic seg_val[5];
        seg_len[0] = DEB + 3; seg_val[0] = 1'b1;
        seg_len[1] = 2;       seg_val[1] = 1'b0;
        seg_len[2] = 3;       seg_val[2] = 1'b1;
        seg_len[3] = DEB;     seg_val[3] = 1'b0;
        seg_len[4] = 2;       seg_val[4] = 1'b1;
        step();
        expect_ev(cyc + DEB + 3, K_PRESS);
        for (int s = 0; s < 5; s++) begin
            touch_key = seg_val[s];
            repeat (seg_len[s]) begin
                step();
                vectors++;
                if ({key_level, key_press, key_release, key_long} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                    miscompares++;
                    $display("FAIL bounce_seg%0d cyc=%0d got=%b want=%b", s, cyc,
                             {key_level, key_press, key_release, key_long}, {exp_lvl, exp_p, exp_r, exp_l});
                end
            end
        end
        touch_key = 1'b0;
        expect_ev(cyc + DEB + 3, K_RELEASE);
        repeat (DEB + 6) begin
            step();
            vectors++;
            if ({key_level, key_press, key_release, key_long} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                miscompares++;
                $display("FAIL bounce_release cyc=%0d got=%b want=%b", cyc,
                         {key_level, key_press, key_release, key_long}, {exp_lvl, exp_p, exp_r, exp_l});
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL bounce_pending got=%0d want=0 events", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_long_press();
        int p_cyc;
        step();
        touch_key = 1'b1;
        p_cyc = cyc + DEB + 3;
        expect_ev(p_cyc, K_PRESS);
`ifdef TOUCH_KEY_LONG_PRESS_EN
        expect_ev(p_cyc + LONG - 1, K_LONG);
`endif
        repeat (DEB + 3 + 40) begin
            step();
            vectors++;
            if ({key_level, key_press, key_release, key_long} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                miscompares++;
                $display("FAIL long_hold cyc=%0d got=%b want=%b", cyc,
                         {key_level, key_press, key_release, key_long}, {exp_lvl, exp_p, exp_r, exp_l});
            end
        end
        touch_key = 1'b0;
        expect_ev(cyc + DEB + 3, K_RELEASE);
        repeat (DEB + 6) begin
            step();
            vectors++;
            if ({key_level, key_press, key_release, key_long} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                miscompares++;
                $display("FAIL long_release cyc=%0d got=%b want=%b", cyc,
                         {key_level, key_press, key_release, key_long}, {exp_lvl, exp_p, exp_r, exp_l});
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL long_pending got=%0d want=0 events", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid_debounce();
        step();
        touch_key = 1'b1;
        repeat (4) begin
            step();
            vectors++;
            if ({key_level, key_press, key_release, key_long} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                miscompares++;
                $display("FAIL midrst_pre cyc=%0d got=%b want=%b", cyc,
                         {key_level, key_press, key_release, key_long}, {exp_lvl, exp_p, exp_r, exp_l});
            end
        end
        sys_rst_n = 1'b0;
        step();
        vectors++;
        if ({key_level, key_press, key_release, key_long} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_in_reset cyc=%0d got=%b want=0000", cyc,
                     {key_level, key_press, key_release, key_long});
        end
        sys_rst_n = 1'b1;
        expect_ev(cyc + DEB + 3, K_PRESS);
        repeat (DEB + 5) begin
            step();
            vectors++;
            if ({key_level, key_press, key_release, key_long} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                miscompares++;
                $display("FAIL midrst_restart cyc=%0d got=%b want=%b", cyc,
                         {key_level, key_press, key_release, key_long}, {exp_lvl, exp_p, exp_r, exp_l});
            end
        end
        touch_key = 1'b0;
        expect_ev(cyc + DEB + 3, K_RELEASE);
        repeat (DEB + 6) begin
            step();
            vectors++;
            if ({key_level, key_press, key_release, key_long} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                miscompares++;
                $display("FAIL midrst_release cyc=%0d got=%b want=%b", cyc,
                         {key_level, key_press, key_release, key_long}, {exp_lvl, exp_p, exp_r, exp_l});
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL midrst_pending got=%0d want=0 events", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_release_bounce();
        test_long_press();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
